// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus widths, mode encodings and bus master state type
package bus_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 8;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } bus_mst_state_t;

endpackage

// File: rtl/bus_master.sv
// rtl/bus_master.sv - system bus initiator: one command in flight, registered bus and response outputs
// BUS_MASTER_TIMEOUT_EN adds a REQ timeout that completes the transaction with rsp_err=1.
module bus_master
    import bus_pkg::*;
#(
    parameter int ADDR_W      = BUS_ADDR_W,
    parameter int DATA_W      = BUS_DATA_W,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mode,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              valid,
    input  logic [DATA_W-1:0] rdata,
    input  logic              ready,
    output logic              busy
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("bus_master: TIMEOUT_CYC must be within 1..65535");
    end

    bus_mst_state_t    state_q;
    logic              mode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              valid_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] cnt_q;
    logic        rsp_err_q;
`endif

    // RSP always falls through to IDLE before the next accept, which guarantees
    // the two-cycle valid-low gap between back-to-back transactions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= MODE_READ;
            addr_q      <= '0;
            wdata_q     <= '0;
            valid_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef BUS_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        mode_q  <= cmd_write ? MODE_WRITE : MODE_READ;
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        valid_q <= 1'b1;
                        state_q <= REQ;
`ifdef BUS_MASTER_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                REQ: begin
                    // ready in the expiry cycle still completes normally
                    if (ready) begin
                        valid_q     <= 1'b0;
                        rsp_rdata_q <= (mode_q == MODE_READ) ? rdata : '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
`ifdef BUS_MASTER_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                    end
`ifdef BUS_MASTER_TIMEOUT_EN
                    else if (cnt_q == TO_LAST) begin
                        valid_q     <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        state_q     <= RSP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
`endif
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mode      = mode_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign valid     = valid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
`ifdef BUS_MASTER_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master.sv
// tb/tb_bus_master.sv - directed self-checking bench for bus_master
module tb_bus_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        mode;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        valid;
    logic [7:0]  rdata;
    logic        ready;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    int          valid_cnt;
    int          rsp_lat;
    logic        cap_mode;
    logic [15:0] cap_addr;
    logic [7:0]  cap_wdata;
    logic [7:0]  got_rdata;
    logic        got_err;
    logic        valid_after;

    bus_master #(
        .ADDR_W      (16),
        .DATA_W      (8),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mode      (mode),
        .addr      (addr),
        .wdata     (wdata),
        .valid     (valid),
        .rdata     (rdata),
        .ready     (ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one command with rsp_ready=1; the slave pulses ready at negedge ready_at
    // (counted from the negedge after acceptance), 0 means never.
    task automatic run_txn(input logic w, input logic [15:0] a, input logic [7:0] d,
                           input logic [7:0] rd, input int ready_at);
        @(negedge clk);
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        valid_cnt = 0;
        rsp_lat   = -1;
        for (int n = 1; n <= 40 && rsp_lat < 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                cmd_valid = 1'b0;
                cap_mode  = mode;
                cap_addr  = addr;
                cap_wdata = wdata;
            end
            ready = (n == ready_at);
            rdata = (n == ready_at) ? rd : 8'h3C;
            if (valid && !ready) valid_cnt++;
            if (n == ready_at + 1) valid_after = valid;
            if (rsp_valid) begin
                rsp_lat   = n - 1;
                got_rdata = rsp_rdata;
                got_err   = rsp_err;
            end
        end
        ready = 1'b0;
        rdata = 8'h00;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; rsp_ready = 1'b0; rdata = '0; ready = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({valid, rsp_valid, rsp_err, mode, addr, wdata, rsp_rdata} !== 36'h0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {valid, rsp_valid, rsp_err, mode, addr, wdata, rsp_rdata});
        else n_pass++;
        n_total++;
        if ({cmd_ready, busy} !== 2'b10)
            $display("FAIL reset_cmd_ready_busy: got %b expected 10", {cmd_ready, busy});
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_write;
        run_txn(1'b1, 16'h0123, 8'hA5, 8'hFF, 5);
        n_total++;
        if (valid_cnt !== 4) $display("FAIL write_valid_cycles: got %0d expected 4", valid_cnt);
        else n_pass++;
        n_total++;
        if ({cap_mode, cap_addr, cap_wdata} !== {1'b1, 16'h0123, 8'hA5})
            $display("FAIL write_bus_fields: got %h expected %h",
                     {cap_mode, cap_addr, cap_wdata}, {1'b1, 16'h0123, 8'hA5});
        else n_pass++;
        n_total++;
        if (rsp_lat !== 5) $display("FAIL write_rsp_latency: got %0d expected 5", rsp_lat);
        else n_pass++;
        n_total++;
        if ({got_err, got_rdata} !== 9'h000)
            $display("FAIL write_rsp_fields: got %h expected 000", {got_err, got_rdata});
        else n_pass++;
    endtask

    task automatic test_readback;
        run_txn(1'b0, 16'h0123, 8'h00, 8'hA5, 5);
        n_total++;
        if ({got_err, got_rdata} !== 9'h0A5)
            $display("FAIL read_rsp_fields: got %h expected 0a5", {got_err, got_rdata});
        else n_pass++;
        n_total++;
        if (valid_after !== 1'b0)
            $display("FAIL read_valid_after_ready: got %b expected 0", valid_after);
        else n_pass++;
        n_total++;
        if ({cap_mode, cap_addr, rsp_lat} !== {1'b0, 16'h0123, 32'd5})
            $display("FAIL read_mode_addr_lat: got %h expected %h",
                     {cap_mode, cap_addr, rsp_lat}, {1'b0, 16'h0123, 32'd5});
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int bad;
        @(negedge clk);
        rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1;
        cmd_addr = 16'h0789; cmd_wdata = 8'h3C;
        @(negedge clk);
        cmd_write = 1'b0; cmd_addr = 16'h0456; cmd_wdata = 8'h00;
        ready = 1'b1; rdata = 8'hEE;
        @(negedge clk);
        ready = 1'b0; rdata = 8'h00;
        n_total++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== 10'h200)
            $display("FAIL bp_first_rsp: got %h expected 200", {rsp_valid, rsp_err, rsp_rdata});
        else n_pass++;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00 || rsp_err !== 1'b0 ||
                cmd_ready !== 1'b0 || valid !== 1'b0 || addr !== 16'h0789 || busy !== 1'b1)
                bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL bp_hold_stable: got %0d bad cycles expected 0", bad);
        else n_pass++;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if ({rsp_valid, cmd_ready, valid} !== 3'b010)
            $display("FAIL bp_release: got %b expected 010", {rsp_valid, cmd_ready, valid});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({valid, mode, addr} !== {1'b1, 1'b0, 16'h0456})
            $display("FAIL bp_second_accept: got %h expected %h",
                     {valid, mode, addr}, {1'b1, 1'b0, 16'h0456});
        else n_pass++;
        cmd_valid = 1'b0; ready = 1'b1; rdata = 8'h77;
        @(negedge clk);
        ready = 1'b0; rdata = 8'h00;
        n_total++;
        if ({rsp_valid, rsp_rdata} !== 9'h177)
            $display("FAIL bp_second_rsp: got %h expected 177", {rsp_valid, rsp_rdata});
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_timeout;
`ifdef BUS_MASTER_TIMEOUT_EN
        run_txn(1'b0, 16'h0ABC, 8'h00, 8'h00, 0);
        n_total++;
        if ({valid_cnt, rsp_lat} !== {32'd8, 32'd8})
            $display("FAIL timeout_cycles: got valid %0d rsp %0d expected 8 8", valid_cnt, rsp_lat);
        else n_pass++;
        n_total++;
        if ({got_err, got_rdata} !== 9'h100)
            $display("FAIL timeout_rsp_fields: got %h expected 100", {got_err, got_rdata});
        else n_pass++;
        run_txn(1'b0, 16'h0ABC, 8'h00, 8'h99, 8);
        n_total++;
        if ({got_err, got_rdata, rsp_lat} !== {1'b0, 8'h99, 32'd8})
            $display("FAIL timeout_ready_wins: got %h expected %h",
                     {got_err, got_rdata, rsp_lat}, {1'b0, 8'h99, 32'd8});
        else n_pass++;
`else
        run_txn(1'b0, 16'h0ABC, 8'h00, 8'h99, 30);
        n_total++;
        if ({valid_cnt, rsp_lat} !== {32'd29, 32'd30})
            $display("FAIL no_timeout_wait: got valid %0d rsp %0d expected 29 30", valid_cnt, rsp_lat);
        else n_pass++;
        n_total++;
        if ({got_err, got_rdata} !== 9'h099)
            $display("FAIL no_timeout_rsp_fields: got %h expected 099", {got_err, got_rdata});
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid_req;
        @(negedge clk);
        rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1;
        cmd_addr = 16'h0F0F; cmd_wdata = 8'h5A;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if ({valid, busy} !== 2'b11) $display("FAIL mid_req_pre: got %b expected 11", {valid, busy});
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({valid, rsp_valid, mode, addr, wdata} !== 27'h0)
            $display("FAIL mid_req_async_clear: got %h expected 0",
                     {valid, rsp_valid, mode, addr, wdata});
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({cmd_ready, busy} !== 2'b10)
            $display("FAIL post_reset_idle: got %b expected 10", {cmd_ready, busy});
        else n_pass++;
        ready = 1'b1; rdata = 8'hAA;
        @(negedge clk);
        ready = 1'b0; rdata = 8'h00;
        @(negedge clk);
        n_total++;
        if ({rsp_valid, valid, busy} !== 3'b000)
            $display("FAIL spurious_ready: got %b expected 000", {rsp_valid, valid, busy});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_readback();
        test_back_to_back();
        test_timeout();
        test_reset_mid_req();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bus_master.md
Name: bus_master

Overview:
- Initiator end of the on-chip 8-bit/16-bit-address system bus; drives mode/addr/wdata/valid toward slaves and collects rdata/ready.
- Accepts one command at a time from a local client through a valid/ready command port.
- Returns each completion on a valid/ready response port.
- Slave select (sl) is produced by the external address decoder from addr and is not driven here.

Parameters:
- ADDR_W, 16, bus address width
- DATA_W, 8, bus data width
- TIMEOUT_CYC, 255, max cycles valid is held without ready (only with BUS_MASTER_TIMEOUT_EN); legal range 1..65535

Ports:
- clk  in  1  bus clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  client command present
- cmd_ready  out  1  master can accept command
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  completion present
- rsp_ready  in  1  client takes completion
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_err  out  1  transaction timed out
- mode  out  1  bus direction, 1=write, 0=read
- addr  out  ADDR_W  bus address
- wdata  out  DATA_W  bus write data
- valid  out  1  bus request strobe
- rdata  in  DATA_W  slave read data, qualified by ready
- ready  in  1  slave completion pulse (1 cycle)
- busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, all outputs 0 except cmd_ready=1; mode/addr/wdata=0, counter=0.
- All outputs registered, except cmd_ready and busy, which decode state.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch cmd_write/addr/wdata onto mode/addr/wdata, set valid=1, enter REQ.
- REQ:
  - valid held 1; mode/addr/wdata stable.
  - On ready=1: clear valid; capture rsp_rdata=rdata if mode=0, else 0; rsp_err=0; set rsp_valid=1; enter RSP.
- RSP:
  - rsp_valid/rsp_rdata/rsp_err held until rsp_ready=1; then rsp_valid=0, enter IDLE.
  - cmd_ready=0 throughout RSP.
- Idle gap: valid is low for at least 2 cycles between transactions, so a slave returning to IDLE never re-accepts a stale request.
- Bus field hold: mode/addr/wdata keep their last values when valid=0; they change only on command acceptance.
- Latency vs. a 4-cycle slave:
  - cmd accepted at edge T0 -> valid high T0+.
  - Slave accepts at T1; ready high after T4.
  - rsp_valid high after T5.
  - cmd->rsp = 5 cycles.
- ready outside REQ: ignored, no state change.
- Client back-pressure: cmd_valid is ignored while cmd_ready=0; the client must hold the command.
- Reset mid-transaction: valid and rsp_valid drop immediately (async); the in-flight command is lost, no response is generated.

Optional Feature:
- Macro: BUS_MASTER_TIMEOUT_EN
- Defined:
  - 16-bit counter cleared on REQ entry, incremented each REQ cycle with ready=0.
  - When counter reaches TIMEOUT_CYC-1 without ready: clear valid, set rsp_valid=1, rsp_err=1, rsp_rdata=0, enter RSP.
  - ready in the same cycle as expiry wins: normal completion, rsp_err=0.
- Undefined:
  - No counter; REQ waits indefinitely.
  - rsp_err tied 0.

Decomposition:
- Package bus_pkg holds:
  - ADDR_W, DATA_W defaults
  - MODE_READ=1'b0, MODE_WRITE=1'b1
  - state enum bus_mst_state_t {IDLE, REQ, RSP}, 2 bits
- No sub-module: FSM, response register and timeout counter all live in one module.

Test Plan:
- Write: cmd write addr=0x0123, wdata=0xA5; slave asserts ready 4 cycles after accepting -> valid high exactly 4 cycles, mode=1, addr=0x0123, wdata=0xA5; rsp_valid 5 cycles after accept, rsp_err=0, rsp_rdata=0x00.
- Read-back: read addr=0x0123 with slave rdata=0xA5 during ready -> rsp_rdata=0xA5, rsp_err=0; valid low the cycle after ready.
- Back-pressure: hold rsp_ready=0 for 10 cycles, with cmd_valid high and a second command (read 0x0456) -> rsp fields stable, cmd_ready=0, valid=0; second command accepted the cycle after rsp_ready rises.
- Timeout (macro on, TIMEOUT_CYC=8): slave never asserts ready -> valid drops after 8 cycles, rsp_err=1, rsp_rdata=0. Same test with ready on the 8th cycle -> rsp_err=0.
- Reset mid-REQ: pull rst_n low 2 cycles into REQ -> valid, rsp_valid, mode, addr and wdata read 0 immediately; after release cmd_ready=1, and a spurious ready pulse produces no rsp_valid.
